serial_signed_pow2_divider_ctrl: RTL and testbench
==================================================

// Module: serial_signed_pow2_divider_ctrl
// PURPOSE
//  Multi-cycle controller that divides a signed N-bit operand by 2**shift.
//  Each cycle it applies a 1-bit arithmetic right shift to an internal register.
//  Valid/ready on input and output; sits between a request source and a result
//  consumer wherever a variable signed power-of-2 divide is too costly as a barrel.
// PARAMETERS
//  N   8            operand/result width (bits), N >= 2
//  SW  $clog2(N)    shift-amount width
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    request present
//  in_ready   out  1    controller can accept (IDLE only)
//  in_data    in   N    signed dividend
//  in_shift   in   SW   shift amount S (values > N-1 clamped to N-1)
//  out_valid  out  1    result present (DONE only)
//  out_ready  in   1    consumer accepts result
//  out_data   out  N    signed quotient
//  busy       out  1    1 in SHIFT or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0,
//   out_data=0, count=0, sticky=0. Recovery is synchronous to clk.
//  FSM states are IDLE, SHIFT and DONE:
//   IDLE : in_ready=1. On in_valid, latch reg=in_data and count=min(in_shift,N-1).
//          Also clear sticky. Next state is SHIFT if count!=0, else DONE.
//   SHIFT: each cycle reg <= {reg[N-1],reg[N-1:1]} and sticky |= reg[0].
//          Also count--. When count==1 (last shift), next state is DONE.
//   DONE : out_valid=1, out_data=reg (after optional correction). Stays in DONE
//          while out_ready=0; out_data is held stable. On out_ready go to IDLE.
//  Latency: handshake accept -> out_valid high = S+1 cycles (S=0 -> 1 cycle).
//  Throughput: one op per S+2 cycles min; in_ready is 0 in SHIFT/DONE.
//   No accept in the same cycle as the DONE->IDLE retire.
//  Default rounding: floor (pure arithmetic shift). Example: -100>>>3 = -13.
//  S=N-1 yields 0 for non-negative operands and -1 for negative ones.
//  rst_n low mid-SHIFT/DONE aborts the op. The result is lost and no out_valid
//   is produced. in_valid/in_data/in_shift are ignored outside IDLE.
// CONFIGURATION
//  Macro SIGNED_DIV_ROUND_TO_ZERO_EN:
//   defined  : on the transition into DONE, if reg[N-1]==1 and sticky==1 then
//              reg <= reg + 1. This gives C-style truncation (-100/8 = -12, -1/128 = 0).
//              Latency is unchanged.
//   undefined: no sticky logic; the result is floor (-100/8 = -13, -1/128 = -1).
// STRUCTURE
//  Package serial_signed_pow2_div_pkg holds:
//   typedef enum logic [1:0] {IDLE, SHIFT, DONE} div_state_t
//   function clamp_shift.
//  Sub-module arith_shift_step holds the 1-bit arithmetic shift and sticky-out
//   (combinational). It is instanced once and fed by the data register.
// TESTING (N=8)
//  1. in_data=100, S=3, out_ready=1 -> out_data=12 (0x0C), out_valid 4 cycles
//     after accept.
//  2. in_data=-100 (0x9C), S=3 -> 0xF3 (-13); with _EN defined -> 0xF4 (-12).
//  3. in_data=-1, S=7 -> 0xFF (-1); with _EN -> 0x00. in_data=-128, S=7 -> -1
//     in both builds.
//  4. S=0, in_data=0x5A -> out_valid 1 cycle after accept, out_data=0x5A.
//  5. Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable,
//     in_ready=0. New in_valid is ignored until retire.
//  6. Assert rst_n=0 on the 2nd SHIFT cycle of S=5 -> immediately
//     out_valid=0, in_ready=1, busy=0. Next request completes correctly.

Source files
------------

// File: rtl/serial_signed_pow2_divider_ctrl_pkg.sv
// Shared types and helpers for the serial signed power-of-2 divider controller.
// Contents: div_state_t (controller FSM states), clamp_shift (limits a shift
// amount to the operand width minus one).
package serial_signed_pow2_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } div_state_t;

  // Shifting by N-1 already reaches the 0 / -1 limit, so larger amounts collapse to it.
  function automatic int unsigned clamp_shift(input int unsigned shift, input int unsigned n);
    return (shift > n - 1) ? n - 1 : shift;
  endfunction

endpackage

// File: rtl/serial_signed_pow2_divider_ctrl_if.sv
// Request/result handshake bundle for serial_signed_pow2_divider_ctrl.
// Signals: in_valid/in_ready/in_data/in_shift (request), out_valid/out_ready/
// out_data (result), busy (status). master = requester/consumer side,
// slave = divider side.
interface serial_signed_pow2_divider_ctrl_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) ();

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;

  modport master (
    output in_valid, in_data, in_shift, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/serial_signed_pow2_divider_ctrl_arith_shift_step.sv
// One-bit arithmetic right shift of the divider's data register (combinational).
// Ports: d_i (register value), q_o (d_i >>> 1), sticky_o (the bit shifted out,
// only present when SIGNED_DIV_ROUND_TO_ZERO_EN is defined).
module arith_shift_step #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
  ,
  output logic         sticky_o
`endif
);

  assign q_o = N'($signed(d_i) >>> 1);

`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
  assign sticky_o = d_i[0];
`endif

endmodule

// File: rtl/serial_signed_pow2_divider_ctrl.sv
// Multi-cycle signed divide by 2**shift: one arithmetic right shift per cycle.
// Ports: clk, rst_n (async active-low), bus (slave modport: request in_*,
// result out_*, busy status). All bus outputs are registered.
// Config: SIGNED_DIV_ROUND_TO_ZERO_EN selects truncation toward zero instead
// of the default floor rounding.
module serial_signed_pow2_divider_ctrl
  import serial_signed_pow2_div_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  serial_signed_pow2_divider_ctrl_if.slave     bus
);

  div_state_t    state_q, state_d;
  logic [N-1:0]  reg_q, reg_d;
  logic [N-1:0]  shifted;
  logic [SW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  out_data_q, out_data_d;
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
  logic          sticky_q, sticky_d;
  logic          sticky_out;
`endif

  arith_shift_step #(.N(N)) u_step (
    .d_i      (reg_q),
    .q_o      (shifted)
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
    ,
    .sticky_o (sticky_out)
`endif
  );

  // Next state, datapath and registered-output values
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    count_d = count_q;
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
    sticky_d = sticky_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          reg_d   = bus.in_data;
          count_d = SW'(clamp_shift(32'(bus.in_shift), N));
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
          sticky_d = 1'b0;
`endif
          state_d = (count_d != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        reg_d   = shifted;
        count_d = count_q - SW'(1);
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
        sticky_d = sticky_q | sticky_out;
`endif
        if (count_q == SW'(1)) begin
          state_d = DONE;
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
          // Negative result with lost fraction bits: step floor up to truncation.
          reg_d = shifted + N'(shifted[N-1] & sticky_d);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they are valid as flops.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    out_data_d  = (state_d == DONE) ? reg_d : out_data_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      reg_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_serial_signed_pow2_divider_ctrl.sv
// Directed bench for serial_signed_pow2_divider_ctrl (N=8): results, latency,
// output hold under backpressure, and async reset abort. Expected values follow
// SIGNED_DIV_ROUND_TO_ZERO_EN when it is defined for the build.
module tb_serial_signed_pow2_divider_ctrl;

  localparam int unsigned N = 8;

`ifdef SIGNED_DIV_ROUND_TO_ZERO_EN
  localparam logic [7:0] EXP_M100_S3 = 8'hF4;
  localparam logic [7:0] EXP_M1_S7   = 8'h00;
  localparam logic [7:0] EXP_M100_S5 = 8'hFD;
`else
  localparam logic [7:0] EXP_M100_S3 = 8'hF3;
  localparam logic [7:0] EXP_M1_S7   = 8'hFF;
  localparam logic [7:0] EXP_M100_S5 = 8'hFC;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  serial_signed_pow2_divider_ctrl_if #(.N(N)) bus ();

  serial_signed_pow2_divider_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait (bounded) for the result, check it, then retire it.
  task automatic do_op(input string tag, input logic [7:0] d, input logic [2:0] s,
                       input logic [7:0] exp);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_shift  = s;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(int'(s) + 1));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_retired"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_retired"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_busy_retired"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Busy / in_ready while shifting, then the result of 100 >>> 3
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd100;
    bus.in_shift = 3'd3;
    step();
    bus.in_valid = 1'b0;
    chk("shift_busy", 32'(bus.busy), 32'd1);
    chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
    chk("shift_out_valid", 32'(bus.out_valid), 32'd0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk("p100_s3_latency", 32'(lat), 32'd4);
    chk("p100_s3_data", 32'(bus.out_data), 32'h0C);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("p100_s3_retired", 32'(bus.out_valid), 32'd0);

    // Directed vectors
    do_op("m100_s3", 8'h9C, 3'd3, EXP_M100_S3);
    do_op("m1_s7",   8'hFF, 3'd7, EXP_M1_S7);
    do_op("m128_s7", 8'h80, 3'd7, 8'hFF);
    do_op("p127_s7", 8'h7F, 3'd7, 8'h00);
    do_op("p5a_s0",  8'h5A, 3'd0, 8'h5A);
    do_op("m100_s5", 8'h9C, 3'd5, EXP_M100_S5);
    do_op("p1_s1",   8'h01, 3'd1, 8'h00);

    // Backpressure: -100 >>> 2 = -25, no fraction lost so both builds give 0xE7
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h9C;
    bus.in_shift = 3'd2;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk("hold_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      bus.in_shift = 3'd0;
      chk($sformatf("hold%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d_out_data", i), 32'(bus.out_data), 32'hE7);
      chk($sformatf("hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("hold_retired_in_ready", 32'(bus.in_ready), 32'd1);
    chk("hold_retired_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    step();
    chk("ignored_req_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ignored_req_busy", 32'(bus.busy), 32'd0);

    // Async reset on the second SHIFT cycle aborts the op
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h40;
    bus.in_shift = 3'd5;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_abort_out_valid", 32'(bus.out_valid), 32'd0);
    do_op("post_abort_p40_s5", 8'h40, 3'd5, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
